zbus_arb_rr: RTL and testbench
==============================

Name: zbus_arb_rr

Overview:
- Round-robin arbiter that shares one zbus output (typically the write port of an async zbus FIFO) between RN zbus requesters.
- Supports packet lock: once a requester starts a multi-transfer packet, it keeps the grant until it completes the packet's last transfer.
- Single clock domain; sits between requester masters and the shared downstream zbus.

Parameters:
- BW, 8, bus width of the grouped zbus signals per requester.
- RN, 4, number of requesters (>=2, need not be a power of two).
- SL, $clog2(RN), width of the grant index.
- RR, 1, arbitration mode: 1 round-robin, 0 fixed priority (index 0 highest).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active high
- zi_vld  input  RN  per-requester transfer valid
- zi_lst  input  RN  per-requester last-transfer-of-packet flag, qualified by zi_vld
- zi_bus  input  RN*BW  per-requester bus; requester i occupies bits [i*BW +: BW]
- zi_ack  output  RN  per-requester transfer acknowledge
- zo_vld  output  1  shared transfer valid
- zo_bus  output  BW  shared bus
- zo_lst  output  1  last flag of the selected requester
- zo_ack  input  1  shared transfer acknowledge
- zo_sel  output  SL  index of the currently selected requester
- zo_lck  output  1  packet lock active

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- State registers: ptr (SL bits, round-robin start index), gnt (SL bits, locked owner), lck (1 bit).
- Reset values: ptr=0, gnt=0, lck=0.
- Outputs in reset: zo_sel=0, zo_lck=0, zo_vld=zi_vld[0], zi_ack=zo_ack on bit 0 only.
- State machine, two states:
  - ARB (lck=0): sel = first i with zi_vld[i]=1, scanning ptr, ptr+1, ..., RN-1, 0, ..., ptr-1. With RR=0 the scan always starts at 0. If no requester is valid, sel=ptr.
  - LOCK (lck=1): sel=gnt; all other requesters are ignored.
- Datapath is combinational, with zero latency from a requester to the output:
  - zo_vld = zi_vld[sel]
  - zo_bus = zi_bus[sel]
  - zo_lst = zi_lst[sel]
  - zi_ack[i] = zo_ack & (i==sel)
  - zo_sel = sel, zo_lck = lck
- Transfer: trn = zo_vld & zo_ack. Registers update only on clock edges where trn=1; otherwise all state holds.
- On trn with zo_lst=0:
  - lck<=1, gnt<=sel, ptr unchanged.
  - ARB moves to LOCK; a transfer already in LOCK stays in LOCK.
- On trn with zo_lst=1:
  - lck<=0.
  - ptr <= (sel==RN-1) ? 0 : sel+1, so wrap-around is correct for non power-of-two RN.
  - Moves to ARB.
- A single-transfer packet (lst=1 on its first beat) never locks; it advances ptr directly.
- Backpressure: zo_ack=0 holds everything. A requester's data must remain stable while its vld=1 and ack=0 (zbus rule), and the block does not change sel in that case:
  - In ARB, sel changes only if the currently selected requester drops vld. Requesters must not do this, but the block tolerates it.
  - In LOCK, a dropped vld from the owner inserts idle cycles; the grant is kept.
- Simultaneous requests: exactly one requester gets ack in any cycle, so zi_ack is one-hot or zero.
- With all RN requesters continuously valid and single-beat packets, grants rotate 0,1,...,RN-1,0. Each requester waits at most RN-1 packets.
- Reset mid-packet: lck is cleared immediately and asynchronously, and arbitration restarts from ptr=0. The partial packet is not recovered downstream.
- zo_ack while no requester is valid has no effect.

Test Plan:
- Reset: assert rst with zi_vld=4'b1111 -> zo_sel=0, zo_lck=0, zi_ack=4'b0001 (if zo_ack=1); after release, the first transfer comes from requester 0.
- Round-robin, single beats: zi_vld=4'b1111, zi_lst=4'b1111, zo_ack=1 for 8 cycles -> zo_sel sequence 0,1,2,3,0,1,2,3 and zo_lck always 0.
- Packet lock: requester 1 sends 3 beats (lst 0,0,1) while requesters 0 and 2 are valid, ptr=1 -> zo_sel=1 for 3 transfers, zo_lck=1 after beats 1 and 2, then zo_sel=2, ptr=2.
- Backpressure: zo_ack=0 for 5 cycles mid-packet with the owner valid -> zo_sel, zo_bus, lck and ptr unchanged and zi_ack=0; the resume transfers the held beat exactly once.
- Wrap with RN=3: requester 2 is the last granted with lst=1 and only requester 0 valid -> ptr=0, next zo_sel=0; with RR=0 and zi_vld=3'b110, zo_sel stays 1 for repeated single beats.
- Reset mid-lock: rst pulses after beat 1 of a 4-beat packet from requester 3 -> zo_lck=0 during reset, ptr=0, and arbitration resumes selecting the lowest valid index.

Source files
------------

// File: rtl/zbus_arb_rr.sv
// rtl/zbus_arb_rr.sv - round-robin zbus arbiter with packet lock
// Shares one downstream zbus among RN requesters; a multi-beat packet holds the grant until its last beat.
module zbus_arb_rr #(
    parameter int BW = 8,
    parameter int RN = 4,
    parameter int SL = $clog2(RN),
    parameter int RR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RN-1:0]    zi_vld,
    input  logic [RN-1:0]    zi_lst,
    input  logic [RN*BW-1:0] zi_bus,
    output logic [RN-1:0]    zi_ack,
    output logic             zo_vld,
    output logic [BW-1:0]    zo_bus,
    output logic             zo_lst,
    input  logic             zo_ack,
    output logic [SL-1:0]    zo_sel,
    output logic             zo_lck
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [SL-1:0] ptr, ptr_nxt;
    logic [SL-1:0] gnt, gnt_nxt;
    logic [SL-1:0] sel;
    logic [SL-1:0] sel_arb;
    logic [SL-1:0] scan_start;
    logic [SL:0]   scan_sum;
    logic [SL-1:0] scan_idx;
    logic          found;
    logic          trn;

    // Scan sum is one bit wider so the wrap works for non power-of-two RN.
    always_comb begin
        scan_start = (RR != 0) ? ptr : '0;
        sel_arb    = ptr;
        found      = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < RN; k++) begin
            scan_sum = {1'b0, scan_start} + (SL+1)'(k);
            if (scan_sum >= (SL+1)'(RN)) begin
                scan_sum = scan_sum - (SL+1)'(RN);
            end
            scan_idx = scan_sum[SL-1:0];
            if (!found && zi_vld[scan_idx]) begin
                sel_arb = scan_idx;
                found   = 1'b1;
            end
        end
    end

    // During reset the output is pinned to requester 0.
    assign sel    = rst ? '0 : ((state == LOCK) ? gnt : sel_arb);
    assign zo_sel = sel;
    assign zo_lck = (state == LOCK);
    assign zo_vld = zi_vld[sel];
    assign zo_lst = zi_lst[sel];
    assign zo_bus = zi_bus[sel*BW +: BW];
    assign zi_ack = zo_ack ? (RN'(1) << sel) : '0;
    assign trn    = zo_vld & zo_ack;

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        if (trn) begin
            if (zo_lst) begin
                state_nxt = ARB;
                ptr_nxt   = (sel == SL'(RN-1)) ? '0 : sel + 1'b1;
            end else begin
                state_nxt = LOCK;
                gnt_nxt   = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ARB;
            ptr   <= '0;
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            gnt   <= gnt_nxt;
        end
    end

endmodule

// File: tb/tb_zbus_arb_rr.sv
// tb/tb_zbus_arb_rr.sv - directed self-checking bench for zbus_arb_rr
// Main instance RN=4 round-robin; two RN=3 instances cover wrap-around and fixed priority.
module tb_zbus_arb_rr;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  vld, lst, ack_i;
    logic [31:0] bus;
    logic        zo_vld, zo_lst, zo_ack, zo_lck;
    logic [7:0]  zo_bus;
    logic [1:0]  zo_sel;

    logic [2:0]  w_vld, w_lst, w_ack_i;
    logic [23:0] w_bus;
    logic        w_ovld, w_olst, w_oack, w_lck;
    logic [7:0]  w_obus;
    logic [1:0]  w_sel;

    logic [2:0]  f_vld, f_lst, f_ack_i;
    logic [23:0] f_bus;
    logic        f_ovld, f_olst, f_oack, f_lck;
    logic [7:0]  f_obus;
    logic [1:0]  f_sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    zbus_arb_rr #(.BW(8), .RN(4), .RR(1)) u_dut (
        .clk(clk), .rst(rst), .zi_vld(vld), .zi_lst(lst), .zi_bus(bus), .zi_ack(ack_i),
        .zo_vld(zo_vld), .zo_bus(zo_bus), .zo_lst(zo_lst), .zo_ack(zo_ack),
        .zo_sel(zo_sel), .zo_lck(zo_lck)
    );

    zbus_arb_rr #(.BW(8), .RN(3), .RR(1)) u_w3 (
        .clk(clk), .rst(rst), .zi_vld(w_vld), .zi_lst(w_lst), .zi_bus(w_bus), .zi_ack(w_ack_i),
        .zo_vld(w_ovld), .zo_bus(w_obus), .zo_lst(w_olst), .zo_ack(w_oack),
        .zo_sel(w_sel), .zo_lck(w_lck)
    );

    zbus_arb_rr #(.BW(8), .RN(3), .RR(0)) u_f3 (
        .clk(clk), .rst(rst), .zi_vld(f_vld), .zi_lst(f_lst), .zi_bus(f_bus), .zi_ack(f_ack_i),
        .zo_vld(f_ovld), .zo_bus(f_obus), .zo_lst(f_olst), .zo_ack(f_oack),
        .zo_sel(f_sel), .zo_lck(f_lck)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        vld    = 4'b1111;
        lst    = 4'b1111;
        bus    = 32'h33221100;
        zo_ack = 1'b1;
        w_vld  = 3'b000; w_lst = 3'b111; w_bus = 24'h221100; w_oack = 1'b0;
        f_vld  = 3'b000; f_lst = 3'b111; f_bus = 24'h221100; f_oack = 1'b0;
        #2;
        chk("rst_sel", zo_sel, 0);
        chk("rst_lck", zo_lck, 0);
        chk("rst_ack", ack_i, 4'b0001);
        chk("rst_vld", zo_vld, 1);
        tick();
        chk("rst_edge_sel", zo_sel, 0);
        rst = 1'b0;
        #1;
        chk("first_sel", zo_sel, 0);

        for (int i = 0; i < 8; i++) begin
            chk("rr_sel", zo_sel, i % 4);
            chk("rr_lck", zo_lck, 0);
            chk("rr_bus", zo_bus, (i % 4) * 8'h11);
            chk("rr_ack", ack_i, 4'b0001 << (i % 4));
            tick();
        end

        // one single beat from requester 0 moves ptr to 1
        chk("pre_sel", zo_sel, 0);
        tick();
        vld = 4'b0111;
        lst = 4'b0000;
        #1;
        chk("pk_b1_sel", zo_sel, 1);
        chk("pk_b1_ack", ack_i, 4'b0010);
        chk("pk_b1_lst", zo_lst, 0);
        chk("pk_b1_lck", zo_lck, 0);
        tick();
        chk("pk_b1_lck_after", zo_lck, 1);
        chk("pk_b1_sel_after", zo_sel, 1);
        bus[15:8] = 8'h12;
        #1;
        chk("pk_b2_bus", zo_bus, 8'h12);
        tick();
        chk("pk_b2_lck_after", zo_lck, 1);
        lst       = 4'b0010;
        bus[15:8] = 8'h13;
        zo_ack    = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_sel", zo_sel, 1);
            chk("bp_bus", zo_bus, 8'h13);
            chk("bp_lck", zo_lck, 1);
            chk("bp_ack", ack_i, 4'b0000);
            tick();
        end
        zo_ack = 1'b1;
        #1;
        chk("pk_b3_ack", ack_i, 4'b0010);
        chk("pk_b3_lst", zo_lst, 1);
        tick();
        chk("pk_end_lck", zo_lck, 0);
        chk("pk_end_sel", zo_sel, 2);
        chk("pk_end_ack", ack_i, 4'b0100);
        chk("pk_end_bus", zo_bus, 8'h22);

        vld = 4'b0000;
        #1;
        chk("idle_sel", zo_sel, 2);
        chk("idle_vld", zo_vld, 0);
        tick();
        chk("idle_sel_after", zo_sel, 2);
        chk("idle_lck_after", zo_lck, 0);

        vld = 4'b1000;
        lst = 4'b0000;
        #1;
        chk("rl_sel", zo_sel, 3);
        tick();
        chk("rl_lck", zo_lck, 1);
        vld = 4'b1010;
        rst = 1'b1;
        #1;
        chk("rl_rst_lck", zo_lck, 0);
        chk("rl_rst_sel", zo_sel, 0);
        chk("rl_rst_ack", ack_i, 4'b0001);
        tick();
        rst = 1'b0;
        #1;
        chk("rl_resume_sel", zo_sel, 1);
        chk("rl_resume_lck", zo_lck, 0);
        zo_ack = 1'b0;

        w_vld  = 3'b100;
        w_oack = 1'b1;
        #1;
        chk("w3_sel2", w_sel, 2);
        chk("w3_bus2", w_obus, 8'h22);
        tick();
        w_vld = 3'b001;
        #1;
        chk("w3_wrap_sel", w_sel, 0);
        chk("w3_wrap_lck", w_lck, 0);
        w_vld = 3'b111;
        #1;
        chk("w3_ptr0_sel", w_sel, 0);
        w_oack = 1'b0;

        f_vld  = 3'b110;
        f_oack = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("fp_sel", f_sel, 1);
            chk("fp_ack", f_ack_i, 3'b010);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
